// File: rtl/isa_cache_refill.sv
// ---------------------------------------------------------------------------
// isa_cache_refill
//
// Instruction-side refill stage that sits directly upstream of the DDR cache
// interface (ui_clk domain). It keeps a window of ISA_DEPTH instructions in a
// local array and serves core fetches from that array with a latency of one
// cycle. A fetch outside the window issues one burst read of ISA_DEPTH beats.
// The returned beats are captured, and the pending fetch is then answered
// without the core issuing it again.
//
// Ports:
//   clk, rst                  ui_clk and asynchronous active-low reset
//   fetch_req, fetch_pc       core fetch strobe and instruction index
//   flush                     invalidate the window
//   ins_out, ins_valid        fetched instruction and its one-cycle strobe
//   stall                     fetch not accepted this cycle (combinational)
//   ISA_read_req/_addr,
//   isa_read_len              burst request towards the DDR interface
//   instruction_to_cache,
//   rd_burst_data_valid       returned beat and its strobe
//   rd_cnt_isa                interface beat counter (informational, unused)
//   load_ins_ddr              interface still busy; hold the request back
//
// Optional build macro: ISA_REFILL_PERF_CNT_EN adds the saturating
// performance counters hit_cnt, miss_cnt and fill_cycles.
// ---------------------------------------------------------------------------
module isa_cache_refill #(
    parameter int                          ISA_WIDTH      = 30,
    parameter int                          ISA_DEPTH      = 72,
    parameter int                          PC_WIDTH       = 16,
    parameter int                          DDR_ADDR_WIDTH = 28,
    parameter logic [DDR_ADDR_WIDTH-1:0]   ISA_DDR_BASE   = '0,
    parameter int                          ADDR_STRIDE    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_req,
    input  logic [PC_WIDTH-1:0]       fetch_pc,
    input  logic                      flush,
    output logic [ISA_WIDTH-1:0]      ins_out,
    output logic                      ins_valid,
    output logic                      stall,
    output logic                      ISA_read_req,
    output logic [DDR_ADDR_WIDTH-1:0] ISA_read_addr,
    output logic [9:0]                isa_read_len,
    input  logic [ISA_WIDTH-1:0]      instruction_to_cache,
    input  logic                      rd_burst_data_valid,
    input  logic [9:0]                rd_cnt_isa,
    input  logic                      load_ins_ddr
`ifdef ISA_REFILL_PERF_CNT_EN
    ,
    output logic [31:0]               hit_cnt,
    output logic [31:0]               miss_cnt,
    output logic [31:0]               fill_cycles
`endif
);

    localparam int IDX_W = $clog2(ISA_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_FILL, S_DONE} state_t;

    state_t                  state_q;
    logic                    window_valid_q;
    logic                    flush_pend_q;
    logic [PC_WIDTH-1:0]     base_q;
    logic [PC_WIDTH-1:0]     miss_pc_q;
    logic [IDX_W-1:0]        fill_cnt_q;
    logic [ISA_WIDTH-1:0]    ins_out_q;
    logic                    ins_valid_q;
    logic                    read_req_q;
    logic [DDR_ADDR_WIDTH-1:0] read_addr_q;
    logic [9:0]              read_len_q;

    logic [ISA_WIDTH-1:0]    mem_q [ISA_DEPTH];

    // The beat counter is not needed: beats are indexed by our own counter.
    logic unused_inputs;
    assign unused_inputs = ^rd_cnt_isa;

    // Window check done one bit wider so a window that runs past the top of
    // the PC space cannot wrap around and alias low addresses.
    logic [PC_WIDTH:0]       pc_ext;
    logic [PC_WIDTH:0]       base_ext;
    logic [PC_WIDTH:0]       limit_ext;
    logic [PC_WIDTH-1:0]     offset;
    logic [IDX_W-1:0]        rd_idx;
    logic                    hit;
    logic                    fetch_hit;
    logic                    fetch_miss;

    assign pc_ext     = {1'b0, fetch_pc};
    assign base_ext   = {1'b0, base_q};
    assign limit_ext  = base_ext + (PC_WIDTH+1)'(ISA_DEPTH);
    assign offset     = fetch_pc - base_q;
    assign rd_idx     = offset[IDX_W-1:0];
    assign hit        = window_valid_q && (pc_ext >= base_ext) && (pc_ext < limit_ext);
    // A flush in the same cycle as a fetch wins, so the fetch becomes a miss.
    assign fetch_hit  = (state_q == S_IDLE) && fetch_req && hit && !flush;
    assign fetch_miss = (state_q == S_IDLE) && fetch_req && !(hit && !flush);

    // stall must reject the miss cycle itself, so it cannot be registered.
    assign stall = (state_q == S_REQ) || (state_q == S_FILL) || fetch_miss;

    assign ins_out       = ins_out_q;
    assign ins_valid     = ins_valid_q;
    assign ISA_read_req  = read_req_q;
    assign ISA_read_addr = read_addr_q;
    assign isa_read_len  = read_len_q;

    // Instruction window storage; contents do not need a reset.
    always_ff @(posedge clk) begin
        if (state_q == S_FILL && rd_burst_data_valid) begin
            mem_q[fill_cnt_q] <= instruction_to_cache;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            window_valid_q <= 1'b0;
            flush_pend_q   <= 1'b0;
            base_q         <= '0;
            miss_pc_q      <= '0;
            fill_cnt_q     <= '0;
            ins_out_q      <= '0;
            ins_valid_q    <= 1'b0;
            read_req_q     <= 1'b0;
            read_addr_q    <= '0;
            read_len_q     <= '0;
        end else begin
            ins_valid_q <= 1'b0;
            read_req_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        window_valid_q <= 1'b0;
                    end
                    if (fetch_hit) begin
                        ins_out_q   <= mem_q[rd_idx];
                        ins_valid_q <= 1'b1;
                    end else if (fetch_miss) begin
                        miss_pc_q    <= fetch_pc;
                        flush_pend_q <= 1'b0;
                        state_q      <= S_REQ;
                    end
                end
                S_REQ: begin
                    flush_pend_q <= flush_pend_q | flush;
                    if (!load_ins_ddr) begin
                        read_req_q     <= 1'b1;
                        read_addr_q    <= ISA_DDR_BASE
                                        + DDR_ADDR_WIDTH'(miss_pc_q) * DDR_ADDR_WIDTH'(ADDR_STRIDE);
                        read_len_q     <= 10'(ISA_DEPTH);
                        window_valid_q <= 1'b0;
                        base_q         <= miss_pc_q;
                        fill_cnt_q     <= '0;
                        state_q        <= S_FILL;
                    end
                end
                S_FILL: begin
                    flush_pend_q <= flush_pend_q | flush;
                    if (rd_burst_data_valid) begin
                        fill_cnt_q <= fill_cnt_q + 1'b1;
                        if (fill_cnt_q == IDX_W'(ISA_DEPTH - 1)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // The pending fetch is always answered, but a flush seen
                    // during the refill leaves the window invalid.
                    window_valid_q <= !(flush_pend_q || flush);
                    ins_out_q      <= mem_q[0];
                    ins_valid_q    <= 1'b1;
                    state_q        <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef ISA_REFILL_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic [31:0] fill_cycles_q;

    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;
    assign fill_cycles = fill_cycles_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
            fill_cycles_q <= '0;
        end else begin
            if (fetch_hit && hit_cnt_q != 32'hFFFF_FFFF) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (fetch_miss && miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if ((state_q == S_REQ || state_q == S_FILL) && fill_cycles_q != 32'hFFFF_FFFF) begin
                fill_cycles_q <= fill_cycles_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_isa_cache_refill.sv
module tb_isa_cache_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_pc = '0;
    logic        flush = 1'b0;
    logic [29:0] ins_out;
    logic        ins_valid;
    logic        stall;
    logic        ISA_read_req;
    logic [27:0] ISA_read_addr;
    logic [9:0]  isa_read_len;
    logic [29:0] instruction_to_cache = '0;
    logic        rd_burst_data_valid = 1'b0;
    logic [9:0]  rd_cnt_isa = '0;
    logic        load_ins_ddr = 1'b0;
`ifdef ISA_REFILL_PERF_CNT_EN
    logic [31:0] hit_cnt, miss_cnt, fill_cycles;
`endif

    isa_cache_refill dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .flush(flush),
        .ins_out(ins_out), .ins_valid(ins_valid), .stall(stall),
        .ISA_read_req(ISA_read_req), .ISA_read_addr(ISA_read_addr), .isa_read_len(isa_read_len),
        .instruction_to_cache(instruction_to_cache), .rd_burst_data_valid(rd_burst_data_valid),
        .rd_cnt_isa(rd_cnt_isa), .load_ins_ddr(load_ins_ddr)
`ifdef ISA_REFILL_PERF_CNT_EN
        , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .fill_cycles(fill_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int tb_hits  = 0;
    int tb_miss  = 0;
    logic [31:0] exp_ins[$];
    logic [31:0] exp_addr[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard side: every instruction strobe and every burst request is
    // matched against the oldest expectation pushed by the stimulus.
    always @(negedge clk) begin : monitor
        logic [31:0] e;
        if (rst) begin
            if (ins_valid) begin
                if (exp_ins.size() == 0) begin
                    check_eq("ins_unexpected", 32'(exp_ins.size()), 32'd1);
                end else begin
                    e = exp_ins.pop_front();
                    check_eq("ins_out", 32'(ins_out), e);
                    $display("ins_valid: ins_out=0x%0h", ins_out);
                end
            end
            if (ISA_read_req) begin
                if (exp_addr.size() == 0) begin
                    check_eq("req_unexpected", 32'(exp_addr.size()), 32'd1);
                end else begin
                    e = exp_addr.pop_front();
                    check_eq("read_addr", 32'(ISA_read_addr), e);
                    check_eq("read_len", 32'(isa_read_len), 32'd72);
                    $display("read_req: addr=0x%0h len=%0d", ISA_read_addr, isa_read_len);
                end
            end
        end
    end

    task automatic start_fetch(input logic [15:0] pc, input logic fl);
        @(posedge clk); #1;
        fetch_req = 1'b1;
        fetch_pc  = pc;
        flush     = fl;
    endtask

    task automatic hit_fetch(input logic [15:0] pc, input logic [31:0] expv);
        exp_ins.push_back(expv);
        start_fetch(pc, 1'b0);
        @(negedge clk);
        check_eq("hit_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        fetch_req = 1'b0;
        tb_hits++;
    endtask

    task automatic miss_fetch(input logic [15:0] pc, input logic [31:0] addr,
                              input logic [31:0] first_beat, input logic push_ins, input logic fl);
        exp_addr.push_back(addr);
        if (push_ins) exp_ins.push_back(first_beat);
        start_fetch(pc, fl);
        @(negedge clk);
        check_eq("miss_stall", 32'(stall), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        tb_miss++;
    endtask

    task automatic wait_req(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (ISA_read_req) return;
        end
        check_eq("req_seen", 32'(ISA_read_req), 32'd1);
    endtask

    // Drive beats back to back; the core drops its fetch once stall clears.
    task automatic feed(input int nbeats, input logic [31:0] v0, input int flush_at);
        for (int i = 0; i < nbeats; i++) begin
            @(posedge clk); #1;
            rd_burst_data_valid  = 1'b1;
            instruction_to_cache = 30'(v0 + 32'(i));
            flush                = (i == flush_at);
            @(negedge clk);
            if (!stall) fetch_req = 1'b0;
        end
        @(posedge clk); #1;
        rd_burst_data_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic release_fetch();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!stall) begin
                fetch_req = 1'b0;
                return;
            end
        end
        check_eq("stall_release", 32'(stall), 32'd0);
        fetch_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_eq({pfx, "_ins_out"},   32'(ins_out), 32'd0);
        check_eq({pfx, "_ins_valid"}, 32'(ins_valid), 32'd0);
        check_eq({pfx, "_stall"},     32'(stall), 32'd0);
        check_eq({pfx, "_read_req"},  32'(ISA_read_req), 32'd0);
        check_eq({pfx, "_read_addr"}, 32'(ISA_read_addr), 32'd0);
        check_eq({pfx, "_read_len"},  32'(isa_read_len), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;

        // Cold miss at pc 5, then two extra beats that must be ignored
        miss_fetch(16'd5, 32'h28, 32'h100, 1'b1, 1'b0);
        wait_req(n);
        feed(74, 32'h100, -1);
        release_fetch();

        // Hits inside window [5, 76], including both edges
        hit_fetch(16'd76, 32'h147);
        hit_fetch(16'd5,  32'h100);
        hit_fetch(16'd40, 32'h123);

        // One past the top of the window misses
        miss_fetch(16'd77, 32'h268, 32'h200, 1'b1, 1'b0);
        wait_req(n);
        feed(72, 32'h200, -1);
        release_fetch();

        // Request is held while the interface is busy
        load_ins_ddr = 1'b1;
        miss_fetch(16'd200, 32'h640, 32'h300, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("req_while_busy", 32'(ISA_read_req), 32'd0);
        end
        @(posedge clk); #1;
        load_ins_ddr = 1'b0;
        wait_req(n);
        check_eq("req_latency", 32'(n), 32'd2);
        @(negedge clk);
        check_eq("req_pulse_width", 32'(ISA_read_req), 32'd0);
        feed(72, 32'h300, -1);
        release_fetch();

        // Reset in the middle of a fill
        miss_fetch(16'd300, 32'h960, 32'h0, 1'b0, 1'b0);
        wait_req(n);
        feed(30, 32'h700, -1);
        @(negedge clk);
        rst = 1'b0;
        fetch_req = 1'b0;
        rd_burst_data_valid = 1'b1;
        instruction_to_cache = 30'h7ff;
        #1;
        check_reset_outputs("midfill_reset");
        tb_hits = 0;
        tb_miss = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rd_burst_data_valid = 1'b0;
        miss_fetch(16'd5, 32'h28, 32'h400, 1'b1, 1'b0);
        wait_req(n);
        feed(72, 32'h400, -1);
        release_fetch();
        hit_fetch(16'd6, 32'h401);

        // Flush during fill: pending fetch answered, window left invalid
        miss_fetch(16'd500, 32'hFA0, 32'h500, 1'b1, 1'b0);
        wait_req(n);
        feed(72, 32'h500, 10);
        release_fetch();
        miss_fetch(16'd500, 32'hFA0, 32'h600, 1'b1, 1'b0);
        wait_req(n);
        feed(72, 32'h600, -1);
        release_fetch();
        hit_fetch(16'd501, 32'h601);

        // Flush together with a fetch that would otherwise hit
        miss_fetch(16'd502, 32'hFB0, 32'h800, 1'b1, 1'b1);
        wait_req(n);
        feed(72, 32'h800, -1);
        release_fetch();
        hit_fetch(16'd510, 32'h808);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("ins_queue_empty",  32'(exp_ins.size()), 32'd0);
        check_eq("addr_queue_empty", 32'(exp_addr.size()), 32'd0);
`ifdef ISA_REFILL_PERF_CNT_EN
        check_eq("hit_cnt",  hit_cnt,  32'(tb_hits));
        check_eq("miss_cnt", miss_cnt, 32'(tb_miss));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
